// File: rtl/tlp_frame_parser.sv
// tlp_frame_parser
//   Link-layer TLP framer. Scans a LANES-wide symbol stream (lane 0 earliest)
//   for STP ... END framed TLPs. It also detects nullified (EDB), malformed,
//   undersized and oversized frames. Good frames are decoded by their fmt/type
//   byte and presented on a valid/ready holding register.
//
//   Ports
//     clk, reset         clock (posedge), asynchronous active-low reset
//     data_in, datak     LANES symbols per clock with per-lane K flags
//     out_valid/ready    downstream handshake for the holding register
//     out_data           captured bytes, byte 0 in [7:0], unused bytes zero
//     out_len            number of captured bytes
//     out_type           one-hot {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,IOWr,IORd,MWr,MRd}
//     tlp_count, err_count, null_count, drop_count   wrapping statistics
//
//   Build option: define TLP_PARSER_STATS_EN to build the statistics counters.
//   Without it, the four counter outputs are tied to zero.
module tlp_frame_parser #(
   parameter int LANES     = 1,
   parameter int MAX_BYTES = 32,
   parameter int MIN_BYTES = 18,
   parameter int CNT_W     = 8,
   parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8*LANES-1:0]     data_in,
   input  logic [LANES-1:0]       datak,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [8*MAX_BYTES-1:0] out_data,
   output logic [LEN_W-1:0]       out_len,
   output logic [9:0]             out_type,
   output logic [CNT_W-1:0]       tlp_count,
   output logic [CNT_W-1:0]       err_count,
   output logic [CNT_W-1:0]       null_count,
   output logic [CNT_W-1:0]       drop_count
);

   localparam logic [7:0] K_STP = 8'hFB;
   localparam logic [7:0] K_END = 8'hFD;
   localparam logic [7:0] K_EDB = 8'hFE;

   typedef enum logic {IDLE, FRAME} state_t;

   state_t                 state, nxt_state;
   logic [8*MAX_BYTES-1:0] frame_buf, nxt_buf;
   logic [LEN_W-1:0]       cnt_q, nxt_cnt;
   logic                   close_ev, err_ev, null_ev, done;
   logic                   short_frame, good, err_any, load, drop;

   // An STP in lane 0 opens a fresh buffer; the rest of that cycle is data.
   function automatic logic [8*MAX_BYTES-1:0] stp_fill(input logic [8*LANES-1:0] d);
      stp_fill = '0;
      for (int unsigned i = 1; i < LANES; i++)
         stp_fill[8*(i-1) +: 8] = d[8*i +: 8];
   endfunction

   function automatic logic [9:0] decode_type(input logic [7:0] ft);
      case (ft)
         8'h00, 8'h20: decode_type = 10'b00_0000_0001;
         8'h40, 8'h60: decode_type = 10'b00_0000_0010;
         8'h02:        decode_type = 10'b00_0000_0100;
         8'h42:        decode_type = 10'b00_0000_1000;
         8'h04:        decode_type = 10'b00_0001_0000;
         8'h44:        decode_type = 10'b00_0010_0000;
         8'h05:        decode_type = 10'b00_0100_0000;
         8'h45:        decode_type = 10'b00_1000_0000;
         8'h0A:        decode_type = 10'b01_0000_0000;
         8'h4A:        decode_type = 10'b10_0000_0000;
         default:      decode_type = '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         frame_buf <= '0;
         cnt_q     <= '0;
      end else begin
         state     <= nxt_state;
         frame_buf <= nxt_buf;
         cnt_q     <= nxt_cnt;
      end
   end

   // Lanes are walked in time order; the first K symbol (or an overflowing
   // data byte) ends the scan for this cycle, so later lanes are ignored.
   always_comb begin
      nxt_state = state;
      nxt_buf   = frame_buf;
      nxt_cnt   = cnt_q;
      close_ev  = 1'b0;
      err_ev    = 1'b0;
      null_ev   = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (datak[0] && data_in[7:0] == K_STP) begin
               nxt_buf   = stp_fill(data_in);
               nxt_cnt   = LEN_W'(LANES - 1);
               nxt_state = FRAME;
            end
         end
         FRAME: begin
            for (int unsigned i = 0; i < LANES; i++) begin
               if (!done) begin
                  if (!datak[i]) begin
                     if (nxt_cnt == LEN_W'(MAX_BYTES)) begin
                        err_ev    = 1'b1;
                        nxt_state = IDLE;
                        done      = 1'b1;
                     end else begin
                        for (int unsigned j = 0; j < MAX_BYTES; j++)
                           if (LEN_W'(j) == nxt_cnt)
                              nxt_buf[8*j +: 8] = data_in[8*i +: 8];
                        nxt_cnt = nxt_cnt + LEN_W'(1);
                     end
                  end else begin
                     done      = 1'b1;
                     nxt_state = IDLE;
                     if (data_in[8*i +: 8] == K_END) begin
                        close_ev = 1'b1;
                     end else if (data_in[8*i +: 8] == K_EDB) begin
                        null_ev = 1'b1;
                     end else if (data_in[8*i +: 8] == K_STP && i == 0) begin
                        err_ev    = 1'b1;
                        nxt_buf   = stp_fill(data_in);
                        nxt_cnt   = LEN_W'(LANES - 1);
                        nxt_state = FRAME;
                     end else begin
                        err_ev = 1'b1;
                     end
                  end
               end
            end
         end
         default: nxt_state = IDLE;
      endcase

      short_frame = close_ev && (nxt_cnt < LEN_W'(MIN_BYTES));
      good        = close_ev && !short_frame;
      err_any     = err_ev || short_frame;
      load        = good && (!out_valid || out_ready);
      drop        = good && out_valid && !out_ready;
   end

   // Holding register: a good frame may replace an entry leaving this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_len   <= '0;
         out_type  <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= nxt_buf;
         out_len   <= nxt_cnt;
         out_type  <= decode_type(nxt_buf[23:16]);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef TLP_PARSER_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tlp_count  <= '0;
         err_count  <= '0;
         null_count <= '0;
         drop_count <= '0;
      end else begin
         if (load)    tlp_count  <= tlp_count + CNT_W'(1);
         if (err_any) err_count  <= err_count + CNT_W'(1);
         if (null_ev) null_count <= null_count + CNT_W'(1);
         if (drop)    drop_count <= drop_count + CNT_W'(1);
      end
   end
`else
   logic unused_stats;
   assign unused_stats = ^{err_any, null_ev, drop};
   assign tlp_count    = '0;
   assign err_count    = '0;
   assign null_count   = '0;
   assign drop_count   = '0;
`endif

endmodule

// File: tb/tb_tlp_frame_parser.sv
`timescale 1ns/1ps
module tb_tlp_frame_parser;
   localparam int MAXB = 32;
   localparam int MINB = 18;
   localparam int LW   = 6;

   typedef struct packed { logic k; logic [7:0] b; } sym_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]        d1;
   logic [0:0]        k1;
   logic              r1;
   logic [31:0]       d4;
   logic [3:0]        k4;
   logic              r4;
   logic              v1, v4;
   logic [8*MAXB-1:0] od1, od4;
   logic [LW-1:0]     ol1, ol4;
   logic [9:0]        ot1, ot4;
   logic [7:0]        tc1, ec1, nc1, dc1, tc4, ec4, nc4, dc4;

   tlp_frame_parser #(.LANES(1), .MAX_BYTES(MAXB), .MIN_BYTES(MINB), .CNT_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .data_in(d1), .datak(k1),
      .out_valid(v1), .out_ready(r1), .out_data(od1), .out_len(ol1), .out_type(ot1),
      .tlp_count(tc1), .err_count(ec1), .null_count(nc1), .drop_count(dc1));

   tlp_frame_parser #(.LANES(4), .MAX_BYTES(MAXB), .MIN_BYTES(MINB), .CNT_W(8)) u_dut4 (
      .clk(clk), .reset(reset), .data_in(d4), .datak(k4),
      .out_valid(v4), .out_ready(r4), .out_data(od4), .out_len(ol4), .out_type(ot4),
      .tlp_count(tc4), .err_count(ec4), .null_count(nc4), .drop_count(dc4));

   // sel = 0 exercises the 1-lane instance, sel = 1 the 4-lane instance
   logic              sel;
   logic              v_a;
   logic [8*MAXB-1:0] od_a;
   logic [LW-1:0]     ol_a;
   logic [9:0]        ot_a;
   logic [7:0]        tc_a, ec_a, nc_a, dc_a;
   always_comb begin
      v_a  = sel ? v4  : v1;
      od_a = sel ? od4 : od1;
      ol_a = sel ? ol4 : ol1;
      ot_a = sel ? ot4 : ot1;
      tc_a = sel ? tc4 : tc1;
      ec_a = sel ? ec4 : ec1;
      nc_a = sel ? nc4 : nc1;
      dc_a = sel ? dc4 : dc1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [8*MAXB-1:0] got, input logic [8*MAXB-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: symbol-level framing with a byte queue and an
   // abstract output register.
   logic [7:0]        m_cur[$];
   bit                m_in;
   logic              m_valid;
   logic [8*MAXB-1:0] m_data;
   logic [LW-1:0]     m_len;
   logic [9:0]        m_type;
   int                m_tlp, m_err, m_null, m_drop;
   sym_t              sq[$];
   sym_t              cs[4];

   function automatic logic [9:0] exp_type(input logic [7:0] b);
      int idx;
      case (b)
         8'h00, 8'h20: idx = 0;
         8'h40, 8'h60: idx = 1;
         8'h02: idx = 2;
         8'h42: idx = 3;
         8'h04: idx = 4;
         8'h44: idx = 5;
         8'h05: idx = 6;
         8'h45: idx = 7;
         8'h0A: idx = 8;
         8'h4A: idx = 9;
         default: idx = -1;
      endcase
      return (idx < 0) ? 10'd0 : 10'(1 << idx);
   endfunction

   task automatic model_reset();
      m_cur.delete();
      m_in = 0; m_valid = 0; m_data = '0; m_len = '0; m_type = '0;
      m_tlp = 0; m_err = 0; m_null = 0; m_drop = 0;
   endtask

   task automatic start_frame(input int lanes);
      m_in = 1;
      m_cur.delete();
      for (int j = 1; j < lanes; j++) m_cur.push_back(cs[j].b);
   endtask

   task automatic model_cycle(input int lanes, input logic rdy);
      bit stop = 0;
      bit good = 0;
      for (int i = 0; i < lanes; i++) begin
         if (!stop) begin
            if (!m_in) begin
               if (i == 0 && cs[0].k && cs[0].b == 8'hFB) start_frame(lanes);
               stop = 1;
            end else if (!cs[i].k) begin
               if (m_cur.size() == MAXB) begin m_err++; m_in = 0; stop = 1; end
               else m_cur.push_back(cs[i].b);
            end else begin
               stop = 1;
               if (cs[i].b == 8'hFD) begin
                  m_in = 0;
                  if (m_cur.size() < MINB) m_err++;
                  else good = 1;
               end else if (cs[i].b == 8'hFE) begin
                  m_null++; m_in = 0;
               end else if (cs[i].b == 8'hFB && i == 0) begin
                  m_err++; start_frame(lanes);
               end else begin
                  m_err++; m_in = 0;
               end
            end
         end
      end
      if (good) begin
         if (!m_valid || rdy) begin
            m_valid = 1;
            m_len   = LW'(m_cur.size());
            m_type  = exp_type(m_cur[2]);
            m_data  = '0;
            foreach (m_cur[j]) m_data[8*j +: 8] = m_cur[j];
            m_tlp++;
         end else begin
            m_drop++;
         end
      end else if (rdy) begin
         m_valid = 0;
      end
   endtask

   task automatic compare_all();
      check("out_valid", v_a, m_valid);
      if (m_valid) begin
         check("out_len", ol_a, m_len);
         check("out_type", ot_a, m_type);
         check("out_data", od_a, m_data);
      end
`ifdef TLP_PARSER_STATS_EN
      check("tlp_count", tc_a, 8'(m_tlp));
      check("err_count", ec_a, 8'(m_err));
      check("null_count", nc_a, 8'(m_null));
      check("drop_count", dc_a, 8'(m_drop));
`else
      check("counters_off", {tc_a, ec_a, nc_a, dc_a}, 0);
`endif
   endtask

   task automatic step(input logic rdy);
      int lanes = sel ? 4 : 1;
      for (int i = 0; i < 4; i++) begin
         cs[i] = '0;
         if (i < lanes && sq.size() > 0) cs[i] = sq.pop_front();
      end
      if (!sel) begin
         d1 = cs[0].b; k1 = cs[0].k; r1 = rdy;
         d4 = '0; k4 = '0; r4 = 1'b0;
      end else begin
         d1 = '0; k1 = '0; r1 = 1'b0; r4 = rdy;
         for (int i = 0; i < 4; i++) begin
            d4[8*i +: 8] = cs[i].b;
            k4[i]        = cs[i].k;
         end
      end
      model_cycle(lanes, rdy);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   function automatic logic pick(input int mode);
      if (mode == 0) return 1'b1;
      if (mode == 1) return 1'b0;
      return ($urandom_range(0, 3) != 0);
   endfunction

   task automatic run(input int mode);
      while (sq.size() > 0) step(pick(mode));
      repeat (3) step(pick(mode));
   endtask

   // term = 0 leaves the frame unterminated
   task automatic push_frame(input logic [7:0] ft, input int len, input logic [7:0] term);
      sq.push_back('{k: 1'b1, b: 8'hFB});
      for (int j = 0; j < len; j++)
         sq.push_back('{k: 1'b0, b: (j == 2) ? ft : (j < 2) ? 8'(j) : 8'($urandom)});
      if (term != 8'h00) sq.push_back('{k: 1'b1, b: term});
   endtask

   function automatic logic [7:0] rand_ft();
      case ($urandom_range(0, 13))
         0: return 8'h00;  1: return 8'h20;  2: return 8'h40;  3: return 8'h60;
         4: return 8'h02;  5: return 8'h42;  6: return 8'h04;  7: return 8'h44;
         8: return 8'h05;  9: return 8'h45; 10: return 8'h0A; 11: return 8'h4A;
         12: return 8'h01;
         default: return 8'h7F;
      endcase
   endfunction

   task automatic push_random();
      logic [7:0] term;
      int r;
      if (sel && $urandom_range(0, 3) != 0)
         while (sq.size() % 4 != 0) sq.push_back('{k: 1'b0, b: 8'h00});
      r = $urandom_range(0, 9);
      term = (r <= 5) ? 8'hFD : (r == 6) ? 8'hFE : (r == 7) ? 8'hBC : (r == 8) ? 8'hF7 : 8'h00;
      push_frame(rand_ft(), $urandom_range(8, 36), term);
      repeat ($urandom_range(0, 3)) sq.push_back('{k: 1'b0, b: 8'($urandom)});
   endtask

   task automatic do_reset();
      reset = 1'b0;
      d1 = '0; k1 = '0; r1 = 1'b0; d4 = '0; k4 = '0; r4 = 1'b0;
      sq.delete();
      model_reset();
      #3;
      check("rst_valid", {v1, v4}, 0);
      check("rst_len", {ol1, ol4}, 0);
      check("rst_type", {ot1, ot4}, 0);
      check("rst_data1", od1, 0);
      check("rst_data4", od4, 0);
      check("rst_counters", {tc1, ec1, nc1, dc1, tc4, ec4, nc4, dc4}, 0);
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   initial begin
      sel   = 1'b0;
      reset = 1'b1;
      #1;
      do_reset();

      // 1-lane directed cases
      push_frame(8'h40, 18, 8'hFD); run(0);   // good MWr
      push_frame(8'h00, 10, 8'hFD); run(0);   // undersized
      push_frame(8'h00, 18, 8'hFE); run(0);   // nullified
      push_frame(8'h00, 33, 8'h00);           // overflow, then recovery
      push_frame(8'h20, 18, 8'hFD); run(0);
      push_frame(8'h04, 18, 8'hFD);           // held, then dropped
      push_frame(8'h0A, 18, 8'hFD); run(1);
      step(1'b1); step(1'b1); step(1'b1);
      push_frame(8'h44, 20, 8'h00);           // STP restart inside a frame
      push_frame(8'h4A, 24, 8'hFD); run(0);
      push_frame(8'h4A, 32, 8'hFD); run(0);   // exactly MAX_BYTES

      repeat (60) begin
         push_random();
         run(2);
      end

      // 4-lane instance
      sel = 1'b1;
      do_reset();
      push_frame(8'h40, 18, 8'hFD);           // END lands in lane 3 of cycle 5
      push_frame(8'h4A, 20, 8'hFD); run(0);   // STP in the following cycle
      push_frame(8'h05, 22, 8'hFD); run(0);

      repeat (60) begin
         push_random();
         run(2);
      end

      // reset in the middle of a frame
      push_frame(8'h40, 18, 8'hFD);
      repeat (3) step(1'b1);
      do_reset();
      push_frame(8'h42, 19, 8'hFD); run(0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tlp_frame_parser.md
# tlp_frame_parser

Parametrised PCIe link-layer TLP framer. It takes a multi-lane stream of 8-bit symbols with per-lane K flags and captures variable-length TLPs delimited by STP (K 0xFB) and END (K 0xFD). It decodes the TLP type and hands each good TLP downstream over a valid/ready interface. It also detects nullified (EDB, K 0xFE), malformed, oversized and dropped TLPs, and sits between the descrambled symbol path and the transaction-layer receive logic.

## Interface
- LANES, 1: symbols per clock; legal values 1, 2, 4.
- MAX_BYTES, 32: maximum captured bytes between STP and END.
- MIN_BYTES, 18: minimum legal captured length (2 sequence + 12 header + 4 LCRC).
- CNT_W, 8: width of each statistics counter.
- LEN_W, $clog2(MAX_BYTES+1): width of out_len.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low.
- data_in  in  8*LANES  symbols; lane i is bits [8i+7:8i]; lane 0 is earliest in time.
- datak  in  LANES  per-lane K-symbol flag.
- out_valid  out  1  captured TLP available.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- out_data  out  8*MAX_BYTES  captured bytes; byte 0 (first after STP) is bits [7:0]; unused bytes are 0.
- out_len  out  LEN_W  number of captured bytes.
- out_type  out  10  one-hot {CplD,Cpl,CfgWr1,CfgRd1,CfgWr0,CfgRd0,IOWr,IORd,MWr,MRd}.
- tlp_count, err_count, null_count, drop_count  out  CNT_W each  statistics counters.

## Operation
- There are two capture states, IDLE and FRAME, plus an independent output holding register.
- **IDLE:** the block waits for datak[0] & data_in[7:0]==0xFB. A STP in any other lane is ignored.
  - On STP: clear the buffer and byte count, capture lanes 1..LANES-1 of the same cycle as data bytes 0..LANES-2, and go to FRAME.
- **FRAME:** lanes are scanned 0 to LANES-1. Non-K lanes are appended at the byte count, and the byte count increments by the number of appended lanes.
  - First K lane is 0xFD (END): close the frame. Lanes after it in that cycle are ignored. Go to IDLE.
  - First K lane is 0xFE (EDB): discard the frame, increment null_count, go to IDLE.
  - First K lane is 0xFB (STP) in lane 0: count the current frame as an error and restart capture from this STP (stay in FRAME).
  - First K lane is any other K symbol, or STP not in lane 0: count an error, go to IDLE.
  - Byte count would exceed MAX_BYTES: count an error, discard, go to IDLE. The remaining symbols up to the next STP are ignored.
- **Close validation:** out_len < MIN_BYTES is an error and is discarded.
  - Otherwise the frame is good and is decoded from byte 2 (fmt/type).
  - Decode map: 0x00/0x20 MRd, 0x40/0x60 MWr, 0x02 IORd, 0x42 IOWr, 0x04 CfgRd0, 0x44 CfgWr0, 0x05 CfgRd1, 0x45 CfgWr1, 0x0A Cpl, 0x4A CplD.
  - Any other value gives out_type=0, and the frame is still delivered.
- **Delivery:** a good frame loads the output register if it is empty, or if it is being emptied in the same cycle (out_valid & out_ready). tlp_count increments on the load.
  - If the register is held (out_valid & ~out_ready), the new frame is discarded and drop_count increments. The held frame is not disturbed.
- The input stream has no backpressure; capture never stalls.
- Counters wrap modulo 2^CNT_W.
- Each error event adds exactly 1 to err_count.

## Timing
- Reset values: state IDLE, out_valid 0, out_data 0, out_len 0, out_type 0, all counters 0.
- Latency: END in cycle N gives out_valid=1 in cycle N+1, with out_data, out_len and out_type valid that same cycle.
- out_data, out_len and out_type are stable while out_valid & ~out_ready. out_valid drops the cycle after acceptance unless a new frame loads in the same edge.
- Back-to-back framing: a STP in the cycle immediately after the END cycle is captured.
- Reset asserted mid-frame aborts the frame; nothing is delivered and no counter changes.

## Configuration
- TLP_PARSER_STATS_EN defined: tlp_count, err_count, null_count and drop_count are implemented as described.
- Undefined: the counter registers are not built, and all four outputs are tied to 0. Framing, decode and delivery are unchanged.

## Test plan
- LANES=1, out_ready=1. Send STP, 0x00 0x01, 0x40 + 11 bytes, 4 LCRC bytes, END.
  - Expect out_valid=1 for one cycle, one cycle after END, with out_len=18 and out_type=MWr (bit 1). tlp_count=1.
- LANES=1. Send STP, 10 data bytes, END.
  - Expect no out_valid and err_count=1.
- LANES=1. Send STP, 18 bytes, EDB.
  - Expect null_count=1 and no delivery.
- LANES=1, MAX_BYTES=32. Send STP followed by 33 data bytes.
  - Expect err_count=1.
  - Then send a valid 18-byte TLP; expect it delivered normally.
- LANES=1, out_ready=0. Send two good TLPs, CfgRd0 (0x04) then Cpl (0x0A).
  - Expect the first held with out_type bit 4 and drop_count=1. Raising out_ready accepts the first and out_valid then falls.
- LANES=4. Send STP in lane 0, 18 data bytes, END in lane 3 of cycle 5, STP in lane 0 of cycle 6.
  - Expect out_len=18 and the second frame captured. With TLP_PARSER_STATS_EN undefined, all counters read 0.
